instr_fetch: RTL and testbench

Instruction fetch stage directly upstream of the control decoder. Keeps the program counter, issues word reads to a synchronous instruction memory, and buffers returned words with their PC in a small FIFO. Presents them to `control` through a valid/ready handshake. Supports a one-cycle redirect (flush) for later branch support and an optional halt-on-sentinel feature.

---
 rtl/instr_fetch.sv | 162 ++++++++++++++++
 tb/tb_instr_fetch.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, one outstanding imem read and a small {word, pc} FIFO feeding control.
// Optional FETCH_HALT_EN: fetching stops when the 32'hFC00_0000 sentinel word returns.

module instr_fetch #(
  parameter int ADDR_W   = 32'd8,
  parameter int RESET_PC = 32'd0,
  parameter int DEPTH    = 32'd2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   flush,
  input  logic [ADDR_W-1:0]      flush_pc,
  output logic                   imem_rd,
  output logic [ADDR_W-1:0]      imem_addr,
  input  logic [31:0]            imem_data,
  output logic [31:0]            instr,
  output logic [ADDR_W-1:0]      instr_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   halted
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] RESET_PC_V = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] PC_ZERO    = ADDR_W'(1'b0);
  localparam logic [ADDR_W-1:0] PC_ONE     = ADDR_W'(1'b1);
  localparam logic [PTR_W-1:0]  PTR_ZERO   = PTR_W'(1'b0);
  localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1'b1);
  localparam logic [PTR_W:0]    LVL_ZERO   = (PTR_W+1)'(1'b0);
  localparam logic [PTR_W:0]    LVL_ONE    = (PTR_W+1)'(1'b1);
  localparam logic [PTR_W+1:0]  DEPTH_V    = (PTR_W+2)'(DEPTH);

  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] pend_pc_r;
  logic              pend_r;
  logic [31:0]       word_mem_r [DEPTH];
  logic [ADDR_W-1:0] pc_mem_r   [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W:0]    level_r;
  logic [PTR_W+1:0]  credit_s;
  logic              valid_s;
  logic              pop_s;
  logic              push_s;
  logic              issue_s;
  logic              halted_s;

`ifdef FETCH_HALT_EN
  localparam logic [31:0] SENTINEL = 32'hFC00_0000;

  function automatic logic is_sentinel(input logic [31:0] word);
    return word == SENTINEL;
  endfunction

  logic halted_r;
  logic resp_ok_s;
  logic halt_set_s;

  assign halted_s = halted_r;

  // Response routing: the sentinel sets halt instead of entering the FIFO
  always_comb begin
    resp_ok_s  = pend_r && !flush && !halted_r;
    push_s     = resp_ok_s && !is_sentinel(imem_data);
    halt_set_s = resp_ok_s && is_sentinel(imem_data);
  end

  // Halt flag, cleared only by flush or reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted_r <= 1'b0;
    end else if (flush) begin
      halted_r <= 1'b0;
    end else if (halt_set_s) begin
      halted_r <= 1'b1;
    end
  end
`else
  assign halted_s = 1'b0;

  // Every response not cancelled by a flush enters the FIFO
  always_comb begin
    push_s = pend_r && !flush;
  end
`endif

  // Handshake and credit-based issue; a flush masks valid so no pop can happen
  always_comb begin
    valid_s  = (level_r != LVL_ZERO) && !flush;
    pop_s    = valid_s && instr_ready;
    credit_s = {1'b0, level_r} + (PTR_W+2)'(pend_r) - (PTR_W+2)'(pop_s);
    issue_s  = en && !flush && !halted_s && (credit_s < DEPTH_V);
  end

  assign imem_rd     = issue_s;
  assign imem_addr   = pc_r;
  assign instr       = word_mem_r[rd_ptr_r];
  assign instr_pc    = pc_mem_r[rd_ptr_r];
  assign instr_valid = valid_s;
  assign fifo_level  = level_r;
  assign halted      = halted_s;

  // PC and the single outstanding-read tracker
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r      <= RESET_PC_V;
      pend_r    <= 1'b0;
      pend_pc_r <= PC_ZERO;
    end else if (flush) begin
      pc_r      <= flush_pc;
      pend_r    <= 1'b0;
      pend_pc_r <= pend_pc_r;
    end else begin
      pend_r <= issue_s;
      if (issue_s) begin
        pend_pc_r <= pc_r;
        pc_r      <= pc_r + PC_ONE;
      end
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      level_r  <= LVL_ZERO;
    end else if (flush) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      level_r  <= LVL_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LVL_ONE;
        2'b01:   level_r <= level_r - LVL_ONE;
        default: level_r <= level_r;
      endcase
    end
  end

  // FIFO storage of {word, pc}
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        word_mem_r[i] <= 32'h0;
        pc_mem_r[i]   <= PC_ZERO;
      end
    end else if (push_s) begin
      word_mem_r[wr_ptr_r] <= imem_data;
      pc_mem_r[wr_ptr_r]   <= pend_pc_r;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: streaming, backpressure, enable gating, flush, halt, and a
// second ADDR_W=4 instance for PC wrap. Delivered words are collected and compared at the end.

module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        flush;
  logic [7:0]  flush_pc;
  logic        imem_rd;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic [31:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [1:0]  fifo_level;
  logic        halted;

  logic        en_w;
  logic        flush_w = 1'b0;
  logic [3:0]  flush_pc_w = 4'd0;
  logic        ready_w = 1'b1;
  logic        rd_w;
  logic [3:0]  addr_w;
  logic [31:0] data_w;
  logic [31:0] instr_w;
  logic [3:0]  instr_pc_w;
  logic        valid_w;
  logic [1:0]  level_w;
  logic        halted_w;

  logic [31:0] mem [256];
  logic [31:0] got_pc[$];
  logic [31:0] got_word[$];
  logic [31:0] wrap_pc[$];
  logic [31:0] wrap_word[$];
  logic [31:0] exp_pc[$];
  logic [31:0] exp_word[$];
  logic        pend_m = 1'b0;
  logic        overflow = 1'b0;
  int          max_level = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  instr_fetch #(.ADDR_W(8), .RESET_PC(0), .DEPTH(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .flush_pc(flush_pc),
    .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_data(imem_data),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .fifo_level(fifo_level), .halted(halted)
  );

  instr_fetch #(.ADDR_W(4), .RESET_PC(14), .DEPTH(2)) u_wrap (
    .clk(clk), .rst_n(rst_n), .en(en_w), .flush(flush_w), .flush_pc(flush_pc_w),
    .imem_rd(rd_w), .imem_addr(addr_w), .imem_data(data_w),
    .instr(instr_w), .instr_pc(instr_pc_w), .instr_valid(valid_w),
    .instr_ready(ready_w), .fifo_level(level_w), .halted(halted_w)
  );

  // synchronous instruction memories, data one cycle after the strobe
  always @(posedge clk) begin
    imem_data <= imem_rd ? mem[imem_addr] : 32'hDEAD_BEEF;
    data_w    <= rd_w ? (32'h200 + 32'(addr_w)) : 32'hDEAD_BEEF;
  end

  // collect handshakes and watch for a response landing in a full FIFO
  always @(negedge clk) begin
    if (rst_n) begin
      if (instr_valid && instr_ready) begin
        got_pc.push_back(32'(instr_pc));
        got_word.push_back(instr);
      end
      if (valid_w && ready_w) begin
        wrap_pc.push_back(32'(instr_pc_w));
        wrap_word.push_back(instr_w);
      end
      if (pend_m && !flush && fifo_level == 2'd2 && !(instr_valid && instr_ready)) begin
        overflow <= 1'b1;
      end
      if (int'(fifo_level) > max_level) begin
        max_level <= int'(fifo_level);
      end
      pend_m <= imem_rd;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic add_exp(input logic [31:0] pc, input logic [31:0] word);
    exp_pc.push_back(pc);
    exp_word.push_back(word);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h100 + 32'(i);
    rst_n = 1'b0; en = 1'b0; flush = 1'b0; flush_pc = 8'h00; instr_ready = 1'b0; en_w = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_rd", 32'(imem_rd), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_pc", 32'(imem_addr), 32'd0);
    check("wrap_rst_pc", 32'(addr_w), 32'd14);

    for (int c = 0; c < 40; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      rst_n       = 1'b1;
      en_w        = 1'b1;
      en          = !(c >= 12 && c <= 14);
      instr_ready = !(c >= 3 && c <= 7);
      flush       = (c == 18 || c == 24 || c == 35);
      flush_pc    = (c == 18) ? 8'h20 : 8'h00;
      if (c == 24) mem[3] = 32'hFC00_0000;
      #1;
      case (c)
        0: begin
          check("c0_rd", 32'(imem_rd), 32'd1);
          check("c0_addr", 32'(imem_addr), 32'd0);
          check("c0_valid", 32'(instr_valid), 32'd0);
        end
        1: begin
          check("c1_valid", 32'(instr_valid), 32'd0);
          check("c1_addr", 32'(imem_addr), 32'd1);
        end
        2: begin
          check("c2_valid", 32'(instr_valid), 32'd1);
          check("c2_pc", 32'(instr_pc), 32'd0);
          check("c2_instr", instr, 32'h100);
          check("c2_level", 32'(fifo_level), 32'd1);
        end
        5: begin
          check("bp_level", 32'(fifo_level), 32'd2);
          check("bp_rd", 32'(imem_rd), 32'd0);
          check("bp_valid", 32'(instr_valid), 32'd1);
          check("bp_pc", 32'(instr_pc), 32'd1);
        end
        12, 13, 14: begin
          check("en0_rd", 32'(imem_rd), 32'd0);
          check("en0_pc_hold", 32'(imem_addr), 32'd7);
        end
        15: begin
          check("en1_rd", 32'(imem_rd), 32'd1);
          check("en1_addr", 32'(imem_addr), 32'd7);
        end
        18: begin
          check("fl_valid", 32'(instr_valid), 32'd0);
          check("fl_rd", 32'(imem_rd), 32'd0);
        end
        19: begin
          check("fl_restart_rd", 32'(imem_rd), 32'd1);
          check("fl_restart_addr", 32'(imem_addr), 32'h20);
          check("fl_level", 32'(fifo_level), 32'd0);
        end
        21: begin
          check("fl_first_valid", 32'(instr_valid), 32'd1);
          check("fl_first_pc", 32'(instr_pc), 32'h20);
          check("fl_first_instr", instr, 32'h120);
        end
`ifdef FETCH_HALT_EN
        32: begin
          check("halt_flag", 32'(halted), 32'd1);
          check("halt_rd", 32'(imem_rd), 32'd0);
          check("halt_valid", 32'(instr_valid), 32'd0);
        end
        35: check("halt_in_flush", 32'(halted), 32'd1);
        36: begin
          check("halt_cleared", 32'(halted), 32'd0);
          check("halt_restart_rd", 32'(imem_rd), 32'd1);
          check("halt_restart_addr", 32'(imem_addr), 32'd0);
        end
`else
        32: begin
          check("nohalt_flag", 32'(halted), 32'd0);
          check("nohalt_rd", 32'(imem_rd), 32'd1);
        end
`endif
        38: begin
          check("c38_valid", 32'(instr_valid), 32'd1);
          check("c38_pc", 32'(instr_pc), 32'd0);
          check("c38_instr", instr, 32'h100);
        end
        default: ;
      endcase
    end

    @(negedge clk);
    #1;
    instr_ready = 1'b0;
    en = 1'b0;

    for (int i = 0; i < 8; i++) add_exp(32'(i), 32'h100 + 32'(i));
    for (int i = 0; i < 3; i++) add_exp(32'h20 + 32'(i), 32'h120 + 32'(i));
    for (int i = 0; i < 3; i++) add_exp(32'(i), 32'h100 + 32'(i));
`ifndef FETCH_HALT_EN
    add_exp(32'd3, 32'hFC00_0000);
    for (int i = 4; i < 8; i++) add_exp(32'(i), 32'h100 + 32'(i));
`endif
    for (int i = 0; i < 2; i++) add_exp(32'(i), 32'h100 + 32'(i));

    check("n_delivered", 32'(got_pc.size()), 32'(exp_pc.size()));
    for (int i = 0; i < exp_pc.size() && i < got_pc.size(); i++) begin
      check($sformatf("seq_pc[%0d]", i), got_pc[i], exp_pc[i]);
      check($sformatf("seq_word[%0d]", i), got_word[i], exp_word[i]);
    end

    check("wrap_count", 32'(wrap_pc.size() >= 4), 32'd1);
    if (wrap_pc.size() >= 4) begin
      check("wrap_pc0", wrap_pc[0], 32'd14);
      check("wrap_pc1", wrap_pc[1], 32'd15);
      check("wrap_pc2", wrap_pc[2], 32'd0);
      check("wrap_pc3", wrap_pc[3], 32'd1);
      check("wrap_word0", wrap_word[0], 32'h20E);
      check("wrap_word2", wrap_word[2], 32'h200);
    end

    check("no_overflow", 32'(overflow), 32'd0);
    check("max_level", 32'(max_level), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
